// File: rtl/eth_pkg.sv
// Shared types and width helpers for the GMII 10/100 TX rate adapter.
// Holds the replay FSM states and the default inter-frame gap.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    IFG
  } rd_state_e;

  // 12 byte-times, two nibbles per byte
  localparam int IFG_DEFAULT = 24;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int len_w(input int max_frame);
    return $clog2(max_frame + 1);
  endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port.
// Read data is registered and holds until the next read.
module eth_sdp_ram #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4096,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/gmii_tx_rate_adapter.sv
// GMII to 10/100 TX rate adapter: store-and-forward, nibble replay.
// Define GMII_TX_RATE_ADAPTER_STATS_EN for sent/dropped counters.
module gmii_tx_rate_adapter
  import eth_pkg::*;
#(
  parameter int DATA_DEPTH = 4096,
  parameter int LEN_DEPTH  = 16,
  parameter int MAX_FRAME  = 2047,
  parameter int IFG_CYCLES = IFG_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        eth_10_100m_en,
  input  logic        link,
  input  logic        gmii_tx_en,
  input  logic [7:0]  gmii_txd,
  output logic        e10_100_tx_en,
  output logic [7:0]  e10_100_txd,
  output logic        frame_dropped,
  output logic [15:0] stat_sent,
  output logic [15:0] stat_dropped
);

  localparam int PW  = ptr_w(DATA_DEPTH);
  localparam int AW  = PW - 1;
  localparam int LPW = ptr_w(LEN_DEPTH);
  localparam int LW  = len_w(MAX_FRAME);
  localparam int NW  = LW + 1;
  localparam int GW  = $clog2(IFG_CYCLES + 1);
  localparam logic [LW-1:0] MAXF = LW'(MAX_FRAME);
  localparam logic [GW-1:0] IFGL = GW'(IFG_CYCLES - 1);

  logic [PW-1:0]  r_wptr, r_cptr, r_rptr;
  logic [LW-1:0]  r_len;
  logic           r_active, r_err, r_skip, r_drop;
  logic [LW-1:0]  r_lmem [LEN_DEPTH];
  logic [LPW-1:0] r_lwp, r_lrp;
  rd_state_e      r_state, w_next;
  logic           r_lphase;
  logic [NW-1:0]  r_ncnt;
  logic [GW-1:0]  r_ifg;
  logic [3:0]     r_hi;
  logic           r_tx_en;
  logic [7:0]     r_txd;

  logic          w_start, w_err0, w_skip0, w_full, w_try;
  logic          w_ovf, w_fall, w_we, w_end, w_lfull;
  logic          w_push, w_drop, w_pend;
  logic          w_pop, w_low, w_re, w_fin;
  logic [LW-1:0] w_cnt0, w_flen;
  logic [7:0]    w_rdata;

  eth_sdp_ram #(
    .WIDTH(8),
    .DEPTH(DATA_DEPTH)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_wptr[AW-1:0]),
    .i_wdata(gmii_txd),
    .i_re   (w_re),
    .i_raddr(r_rptr[AW-1:0]),
    .o_rdata(w_rdata)
  );

  // Write side: bytes land speculatively, commit or roll back at frame end
  always_comb begin
    w_start = gmii_tx_en && !r_active;
    w_err0  = w_start ? 1'b0 : r_err;
    w_skip0 = w_start ? 1'b0 : r_skip;
    w_cnt0  = w_start ? '0 : r_len;
    w_full  = (r_wptr[AW] != r_rptr[AW]) &&
              (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    w_try   = gmii_tx_en && eth_10_100m_en && !w_skip0;
    w_ovf   = w_try && !w_err0 && (w_full || w_cnt0 == MAXF);
    w_fall  = gmii_tx_en && r_active && !eth_10_100m_en &&
              r_len != '0 && !w_skip0;
    w_we    = w_try && !w_err0 && !w_ovf;
    w_end   = !gmii_tx_en && r_active && !r_skip;
    w_lfull = (r_lwp[LPW-1] != r_lrp[LPW-1]) &&
              (r_lwp[LPW-2:0] == r_lrp[LPW-2:0]);
    w_push  = w_end && !r_err && r_len != '0 && !w_lfull;
    w_drop  = w_end && (r_err || (r_len != '0 && w_lfull));
    w_pend  = r_lwp != r_lrp;
    w_flen  = r_lmem[r_lrp[LPW-2:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_cptr   <= '0;
      r_len    <= '0;
      r_active <= 1'b0;
      r_err    <= 1'b0;
      r_skip   <= 1'b0;
      r_drop   <= 1'b0;
      r_lwp    <= '0;
    end else if (!link) begin
      r_wptr   <= '0;
      r_cptr   <= '0;
      r_len    <= '0;
      r_active <= gmii_tx_en;
      r_err    <= 1'b0;
      r_skip   <= gmii_tx_en;
      r_drop   <= 1'b0;
      r_lwp    <= '0;
    end else begin
      r_active <= gmii_tx_en;
      r_drop   <= w_drop;
      if (gmii_tx_en) begin
        r_err  <= w_err0 | w_ovf | w_fall;
        r_skip <= w_skip0;
        r_len  <= w_we ? w_cnt0 + LW'(1) : w_cnt0;
      end
      if (w_we) r_wptr <= r_wptr + PW'(1);
      if (w_drop) r_wptr <= r_cptr;
      if (w_push) begin
        r_cptr <= r_wptr;
        r_lwp  <= r_lwp + LPW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_lmem[r_lwp[LPW-2:0]] <= r_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_state <= IDLE;
    else if (!link) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_pend) w_next = LOAD;
      LOAD: if (r_lphase) w_next = SEND;
      SEND: if (r_ncnt == NW'(1)) w_next = IFG;
      IFG:  if (r_ifg == '0) w_next = IDLE;
    endcase
  end

  // Low nibble uses RAM data directly while the next byte is fetched
  always_comb begin
    w_pop = (r_state == LOAD) && !r_lphase;
    w_low = (r_state == SEND) && !r_ncnt[0];
    w_re  = w_pop || (w_low && r_ncnt > NW'(2));
    w_fin = (r_state == SEND) && r_ncnt == NW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr   <= '0;
      r_lrp    <= '0;
      r_lphase <= 1'b0;
      r_ncnt   <= '0;
      r_ifg    <= '0;
      r_hi     <= '0;
      r_tx_en  <= 1'b0;
      r_txd    <= 8'h00;
    end else if (!link) begin
      r_rptr   <= '0;
      r_lrp    <= '0;
      r_lphase <= 1'b0;
      r_ncnt   <= '0;
      r_ifg    <= '0;
      r_hi     <= '0;
      r_tx_en  <= 1'b0;
      r_txd    <= 8'h00;
    end else begin
      r_lphase <= w_pop;
      if (w_pop) begin
        r_lrp  <= r_lrp + LPW'(1);
        r_ncnt <= {w_flen, 1'b0};
      end else if (r_state == SEND) begin
        r_ncnt <= r_ncnt - NW'(1);
      end
      if (w_re) r_rptr <= r_rptr + PW'(1);
      if (w_low) r_hi <= w_rdata[7:4];
      if (w_fin) r_ifg <= IFGL;
      else if (r_state == IFG && r_ifg != '0) r_ifg <= r_ifg - GW'(1);
      r_tx_en <= r_state == SEND;
      if (w_low)                 r_txd <= {2{w_rdata[3:0]}};
      else if (r_state == SEND)  r_txd <= {2{r_hi}};
      else                       r_txd <= 8'h00;
    end
  end

  assign e10_100_tx_en = r_tx_en;
  assign e10_100_txd   = r_txd;
  assign frame_dropped = r_drop;

`ifdef GMII_TX_RATE_ADAPTER_STATS_EN
  logic [15:0] r_sent, r_dropd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sent  <= '0;
      r_dropd <= '0;
    end else if (!link) begin
      r_sent  <= '0;
      r_dropd <= '0;
    end else begin
      if (w_fin && r_sent != 16'hFFFF) r_sent <= r_sent + 16'd1;
      if (w_drop && r_dropd != 16'hFFFF) r_dropd <= r_dropd + 16'd1;
    end
  end

  assign stat_sent    = r_sent;
  assign stat_dropped = r_dropd;
`else
  assign stat_sent    = '0;
  assign stat_dropped = '0;
`endif

endmodule

// File: doc/gmii_tx_rate_adapter.md
# gmii_tx_rate_adapter

Parametrised GMII-to-10/100 transmit rate adapter for the Ethernet TX path. It sits between the GMII frame builder and the 10/100 PHY lane. Each frame is buffered whole in an internal data FIFO, with its length in a length FIFO. Committed frames are replayed as nibbles, one nibble per clk, replicated on both halves of the byte lane. Over its predecessor it adds an overflow/oversize drop with write rollback, a programmable inter-frame gap, link-drop abort and optional statistics.

## Interface
- DATA_DEPTH, 4096: data FIFO depth in bytes, power of two.
- LEN_DEPTH, 16: maximum frames pending, power of two.
- MAX_FRAME, 2047: longest accepted frame in bytes; longer frames are dropped.
- IFG_CYCLES, 24: minimum idle clk between output frames (12 byte-times × 2 nibbles).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- eth_10_100m_en  in  1  adapter enable; when low, nothing is written.
- link  in  1  PHY link; low flushes the block synchronously.
- gmii_tx_en  in  1  GMII frame valid.
- gmii_txd  in  8  GMII byte.
- e10_100_tx_en  out  1  nibble-lane enable.
- e10_100_txd  out  8  current nibble in both [7:4] and [3:0].
- frame_dropped  out  1  one-clk pulse per dropped frame.
- stat_sent  out  16  frames sent, saturating.
- stat_dropped  out  16  frames dropped, saturating.

## Operation
- Write side:
  - A byte is written when gmii_tx_en && eth_10_100m_en.
  - The write pointer advances speculatively; the committed pointer does not.
  - The frame ends on the first cycle gmii_tx_en is sampled low after high. That cycle is the commit cycle.
- Commit: if no error and the length FIFO is not full, push len (1..MAX_FRAME) and set committed ← write pointer.
- Otherwise drop: write pointer ← committed pointer, pulse frame_dropped.
- Error flag sets on any of:
  - a write attempted while the data FIFO is full (free space is counted against the read pointer); further bytes are discarded;
  - byte count exceeding MAX_FRAME;
  - eth_10_100m_en falling mid-frame.
- The error flag clears at frame start.
- Read FSM:
  - IDLE: pending>0 → LOAD.
  - LOAD (2 clk): pop length, issue first RAM read → SEND.
  - SEND: 2·len clk, low nibble then high nibble per byte; the next byte is prefetched on each low-nibble clk. Last nibble → IFG.
  - IFG: IFG_CYCLES clk → IDLE.
- Width rules:
  - Pointers are $clog2(DATA_DEPTH)+1 bits, with the MSB as wrap flag: full when the MSBs differ and the rest are equal.
  - Length is $clog2(MAX_FRAME+1) bits; the nibble counter is one bit wider.
- Simultaneous write and read of the RAM in the same clk are legal (dual port). A commit and a length pop in the same clk leave the pending count unchanged.
- link low:
  - both FIFOs empty, all pointers 0, FSM → IDLE, e10_100_tx_en low next clk;
  - an in-flight output frame is truncated and not counted as sent;
  - an in-flight input frame is discarded without a drop pulse.

## Timing
- Reset values: e10_100_tx_en 0, e10_100_txd 8'h00, frame_dropped 0, stat_* 0, FSM IDLE, pointers 0.
- Outputs are registered.
- Latency: if the commit cycle is edge N, the first nibble appears with e10_100_tx_en high after edge N+4, given an idle FSM.
- e10_100_tx_en stays high for exactly 2·len contiguous clk.
- The gap between consecutive output frames is exactly IFG_CYCLES+3 clk when the next frame is already pending: IFG, then IDLE, then LOAD.
- frame_dropped asserts the clk after the commit cycle.
- Back-to-back GMII frames with a one-cycle gap are accepted.

## Configuration
- GMII_TX_RATE_ADAPTER_STATS_EN defined: stat_sent increments on each completed SEND, and stat_dropped increments with frame_dropped. Both saturate at 16'hFFFF and clear on reset or link low.
- Not defined: no counter logic; stat_sent and stat_dropped are tied to 0. frame_dropped remains.

## Structure
- Package eth_pkg holds:
  - the FSM state enum (IDLE, LOAD, SEND, IFG);
  - the IFG default constant;
  - a helper function for pointer and length widths.
- One sub-module, eth_sdp_ram: simple dual-port, one write port, one read port with 1-clk registered read, parameters WIDTH/DEPTH. It is used for the data FIFO. The length FIFO is a small register array inside the top module.

## Test plan
- Single 64-byte frame 0x00..0x3F: 128 nibble clk, with e10_100_txd = 8'h00, 8'h00, 8'h11, 8'h00, 8'h22, …; first nibble after edge N+4.
- Three 60-byte frames with 1-clk gaps: three output bursts of 120 clk each, gaps of 27 clk (IFG_CYCLES=24), stat_sent=3.
- DATA_DEPTH=128 while holding a pending 100-byte frame, then a 60-byte frame arrives: the 60-byte frame is dropped and frame_dropped pulses once. A following 20-byte frame is sent intact, showing the rollback is clean.
- 2048-byte frame with MAX_FRAME=2047: dropped, stat_dropped=1, no output burst.
- link low in the middle of SEND of a 100-byte frame: e10_100_tx_en low next clk. After link high, a fresh 10-byte frame is sent correctly.
- LEN_DEPTH=2 with the output stalled by a long frame: three short frames arrive, and the third is dropped.
